// File: rtl/fp_result_serializer_if.sv
// Bundle of result-capture and byte-link signals for fp_result_serializer.
// Latency: none (wires only).
// Backpressure: tx_ready from the UART side; the result side cannot be stalled.
interface fp_result_serializer_if;
  logic [31:0] result;
  logic        result_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        fifo_full;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        busy;

  // Producer/consumer side (drives results, accepts bytes)
  modport master (
    output result, result_valid, tx_ready,
    input  tx_data, tx_valid, fifo_full, overflow, drop_count, busy
  );

  // Serializer side
  modport slave (
    input  result, result_valid, tx_ready,
    output tx_data, tx_valid, fifo_full, overflow, drop_count, busy
  );
endinterface

// File: rtl/fp_result_serializer.sv
// Buffers FP32 add/sub results in a FIFO and drains each word as 4 bytes (valid/ready).
// Latency: result sampled at edge k -> tx_valid high after edge k+1; 1 byte/cycle with tx_ready=1.
// Backpressure: tx_ready stalls bytes; words arriving to a full FIFO are dropped and counted.
// Build option FP_SER_SYNC_BYTE_EN: each word is preceded by the sync byte 8'hA5.
module fp_result_serializer #(
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input logic                   clk,
  input logic                   reset,
  fp_result_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

`ifdef FP_SER_SYNC_BYTE_EN
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_SEND} state_t;
  localparam state_t S_FIRST = S_SYNC;
`else
  typedef enum logic {S_IDLE, S_SEND} state_t;
  localparam state_t S_FIRST = S_SEND;
`endif

  logic [31:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  state_t      r_state;
  logic        r_overflow;
  logic [7:0]  r_drop_count;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  state_t      w_state_nxt;
  logic [1:0]  w_idx_nxt;
  logic        w_tx_valid;
  logic [7:0]  w_tx_data;
  logic [1:0]  w_byte_sel;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the word.
  assign w_push = bus.result_valid && (!w_full || w_pop);
  assign w_drop = bus.result_valid && w_full && !w_pop;

  // Byte lane for the current index; lane 3 is bits [31:24].
  assign w_byte_sel = (MSB_FIRST != 0) ? (2'd3 - r_idx) : r_idx;

  // Next-state, pop request and byte-link outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    w_tx_valid  = 1'b0;
    w_tx_data   = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_FIRST;
        end
      end
`ifdef FP_SER_SYNC_BYTE_EN
      S_SYNC: begin
        w_tx_valid = 1'b1;
        w_tx_data  = 8'hA5;
        if (bus.tx_ready) begin
          w_state_nxt = S_SEND;
        end
      end
`endif
      S_SEND: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_shift[{w_byte_sel, 3'b000} +: 8];
        if (bus.tx_ready) begin
          if (r_idx != 2'd3) begin
            w_idx_nxt = r_idx + 2'd1;
          end else if (!w_empty) begin
            // Back-to-back words: load the next one on the last accept, no bubble.
            w_pop       = 1'b1;
            w_idx_nxt   = 2'd0;
            w_state_nxt = S_FIRST;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, byte index and the word being serialized.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_shift <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pop) begin
        r_shift <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  // FIFO pointers; reset empties the queue and discards pending words.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.result;
    end
  end

  // Drop pulse lands one cycle after the dropping edge; counter saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 8'h00;
    end else begin
      r_overflow <= w_drop;
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'h01;
      end
    end
  end

  assign bus.tx_valid   = w_tx_valid;
  assign bus.tx_data    = w_tx_data;
  assign bus.fifo_full  = w_full;
  assign bus.overflow   = r_overflow;
  assign bus.drop_count = r_drop_count;
  assign bus.busy       = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_fp_result_serializer.sv
// Bench for fp_result_serializer: MSB-first and LSB-first instances share stimulus
// and are compared each cycle against a word/byte queue model of the serializer.
module tb_fp_result_serializer;
  localparam int DEPTH = 4;
`ifdef FP_SER_SYNC_BYTE_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  localparam int NB = 4 + SYNC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] result;
  logic        result_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  fp_result_serializer_if if_m ();
  fp_result_serializer_if if_l ();

  assign if_m.result       = result;
  assign if_m.result_valid = result_valid;
  assign if_m.tx_ready     = tx_ready;
  assign if_l.result       = result;
  assign if_l.result_valid = result_valid;
  assign if_l.tx_ready     = tx_ready;

  fp_result_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1)) u_dut_msb (
    .clk(clk), .reset(reset), .bus(if_m));
  fp_result_serializer #(.DEPTH(DEPTH), .MSB_FIRST(0)) u_dut_lsb (
    .clk(clk), .reset(reset), .bus(if_l));

  // ---------------- behavioural model ----------------
  // m_fifo: words waiting; m_word/m_rem: word on the link and bytes still to send.
  logic [31:0] m_fifo[$];
  logic [31:0] m_word;
  int          m_rem   = 0;
  bit          m_ovf   = 0;
  int          m_drops = 0;
  bit          m_live  = 0;
  bit          mb_acc, mb_pop, mb_full;

  always @(posedge clk) begin
    if (reset === 1'b0) begin
      m_fifo.delete();
      m_rem   = 0;
      m_ovf   = 0;
      m_drops = 0;
      m_live  = 1;
    end else if (m_live) begin
      mb_acc  = (m_rem > 0) && tx_ready;
      mb_pop  = (m_fifo.size() > 0) && ((m_rem == 0) || (mb_acc && m_rem == 1));
      mb_full = (m_fifo.size() == DEPTH);
      m_ovf   = 0;
      if (mb_acc) m_rem--;
      if (mb_pop) begin
        m_word = m_fifo.pop_front();
        m_rem  = NB;
      end
      if (result_valid) begin
        if (!mb_full || mb_pop) m_fifo.push_back(result);
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  end

  function automatic logic [7:0] exp_byte(logic [31:0] w, int rem, bit msb);
    int pos, k;
    pos = NB - rem;
    if (SYNC != 0 && pos == 0) return 8'hA5;
    k = pos - SYNC;
    if (msb) k = 3 - k;
    return w[8*k +: 8];
  endfunction

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] q_msb[$];
  logic [7:0] q_lsb[$];
  int         q_cyc[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp(string tag, bit msb, logic vld, logic [7:0] dat, logic full,
                     logic ovf, logic [7:0] cnt, logic bsy);
    chk({tag, ".tx_valid"}, vld, m_rem > 0);
    if (m_rem > 0) chk({tag, ".tx_data"}, dat, exp_byte(m_word, m_rem, msb));
    chk({tag, ".fifo_full"}, full, m_fifo.size() == DEPTH);
    chk({tag, ".overflow"}, ovf, m_ovf);
    chk({tag, ".drop_count"}, cnt, m_drops);
    chk({tag, ".busy"}, bsy, (m_rem > 0) || (m_fifo.size() > 0));
  endtask

  // One clock: log bytes about to be accepted, then compare after the edge.
  task automatic step();
    if (m_live && reset && if_m.tx_valid && tx_ready) begin
      q_msb.push_back(if_m.tx_data);
      q_cyc.push_back(cyc);
    end
    if (m_live && reset && if_l.tx_valid && tx_ready) q_lsb.push_back(if_l.tx_data);
    @(negedge clk);
    cyc++;
    if (m_live) begin
      cmp("msb", 1'b1, if_m.tx_valid, if_m.tx_data, if_m.fifo_full, if_m.overflow,
          if_m.drop_count, if_m.busy);
      cmp("lsb", 1'b0, if_l.tx_valid, if_l.tx_data, if_l.fifo_full, if_l.overflow,
          if_l.drop_count, if_l.busy);
    end
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((if_m.busy || if_l.busy) && n < budget) begin
      step();
      n++;
    end
    chk({name, ".drain_in_budget"}, n < budget, 1'b1);
  endtask

  task automatic clear_logs();
    q_msb.delete();
    q_lsb.delete();
    q_cyc.delete();
  endtask

  logic [7:0]  pi_m [4] = '{8'h40, 8'h49, 8'h0F, 8'hDB};
  logic [7:0]  pi_l [4] = '{8'hDB, 8'h0F, 8'h49, 8'h40};
  logic [31:0] strm [3] = '{32'h40490FDB, 32'hC2F60000, 32'h3F800000};
  bit          bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check_pi(string name);
    chk({name, ".msb_count"}, q_msb.size(), NB);
    chk({name, ".lsb_count"}, q_lsb.size(), NB);
    for (int k = 0; k < NB && k < q_msb.size() && k < q_lsb.size(); k++) begin
      chk({name, ".msb_byte"}, q_msb[k], (SYNC != 0 && k == 0) ? 8'hA5 : pi_m[k-SYNC]);
      chk({name, ".lsb_byte"}, q_lsb[k], (SYNC != 0 && k == 0) ? 8'hA5 : pi_l[k-SYNC]);
    end
  endtask

  initial begin
    int ovf_seen;
    int n;
    reset        = 1'b0;
    result       = 32'h0;
    result_valid = 1'b0;
    tx_ready     = 1'b0;

    // Reset: two edges low, then release.
    step();
    step();
    reset = 1'b1;
    chk("reset.tx_valid", if_m.tx_valid, 1'b0);
    chk("reset.tx_data", if_m.tx_data, 8'h00);
    chk("reset.fifo_full", if_m.fifo_full, 1'b0);
    chk("reset.overflow", if_m.overflow, 1'b0);
    chk("reset.drop_count", if_m.drop_count, 8'h00);
    chk("reset.busy", if_m.busy, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Single word with latency: stored at edge k, tx_valid after edge k+1.
    clear_logs();
    result       = 32'h40490FDB;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    chk("single.tx_valid_after_k", if_m.tx_valid, 1'b0);
    chk("single.busy_after_k", if_m.busy, 1'b1);
    step();
    chk("single.tx_valid_after_k1", if_m.tx_valid, 1'b1);
    chk("single.first_byte", if_m.tx_data, (SYNC != 0) ? 8'hA5 : 8'h40);
    drain("single", 20);
    check_pi("single");
    chk("single.busy_end", if_m.busy, 1'b0);

    // Backpressure: tx_ready pattern 1,0,0,1 repeating.
    clear_logs();
    result       = 32'h40490FDB;
    result_valid = 1'b1;
    tx_ready     = bp_pat[0];
    step();
    result_valid = 1'b0;
    n = 1;
    while ((if_m.busy || if_l.busy) && n < 60) begin
      tx_ready = bp_pat[n % 4];
      step();
      n++;
    end
    chk("bp.drain_in_budget", n < 60, 1'b1);
    check_pi("bp");

    // Overflow with tx_ready=0: one word moves into the shift register, so the
    // FIFO fills on the 5th pulse and the 6th and 7th are dropped.
    clear_logs();
    tx_ready = 1'b0;
    ovf_seen = 0;
    for (int i = 0; i < 7; i++) begin
      result       = 32'h3F800000 + i;
      result_valid = 1'b1;
      step();
      if (if_m.overflow) ovf_seen++;
      if (i == 3) chk("ovf.not_full_after_4", if_m.fifo_full, 1'b0);
      if (i == 4) chk("ovf.full_after_5", if_m.fifo_full, 1'b1);
    end
    result_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (if_m.overflow) ovf_seen++;
    end
    chk("ovf.pulses", ovf_seen, 2);
    chk("ovf.drop_count", if_m.drop_count, 8'd2);
    chk("ovf.fifo_full", if_m.fifo_full, 1'b1);
    tx_ready = 1'b1;
    drain("ovf", 80);
    chk("ovf.byte_count", q_msb.size(), 5 * NB);
    chk("ovf.first_data_byte", (q_msb.size() > SYNC) ? q_msb[SYNC] : 8'hxx, 8'h3F);
    for (int j = 0; j < 5; j++) begin
      for (int p = 0; p < NB; p++) begin
        if (j * NB + p < q_msb.size())
          chk("ovf.order", q_msb[j*NB+p], exp_byte(32'h3F800000 + j, NB - p, 1'b1));
      end
    end

    // Saturation of the drop counter.
    tx_ready     = 1'b0;
    result_valid = 1'b1;
    for (int i = 0; i < 265; i++) begin
      result = 32'h1000 + i;
      step();
    end
    result_valid = 1'b0;
    step();
    chk("sat.drop_count", if_m.drop_count, 8'hFF);
    tx_ready = 1'b1;
    drain("sat", 80);

    // Stream: three back-to-back words, bytes on consecutive cycles.
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      result       = strm[i];
      result_valid = 1'b1;
      step();
    end
    result_valid = 1'b0;
    drain("stream", 40);
    chk("stream.byte_count", q_msb.size(), 3 * NB);
    chk("stream.lsb_count", q_lsb.size(), 3 * NB);
    if (q_cyc.size() == 3 * NB)
      chk("stream.no_bubble", q_cyc[3*NB-1] - q_cyc[0], 3 * NB - 1);
    if (q_lsb.size() == 3 * NB) begin
      chk("stream.lsb_w0_first", q_lsb[SYNC], 8'hDB);
      chk("stream.lsb_w1_last", q_lsb[2*NB-1], 8'hC2);
      chk("stream.msb_w1_first", q_msb[NB+SYNC], 8'hC2);
    end

    // Reset after the 2nd data byte of a word with another word queued.
    clear_logs();
    for (int i = 0; i < 2; i++) begin
      result       = strm[i];
      result_valid = 1'b1;
      step();
    end
    result_valid = 1'b0;
    n = 0;
    while (q_msb.size() < SYNC + 2 && n < 20) begin
      step();
      n++;
    end
    chk("rst_mid.reached_byte2", n < 20, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_mid.tx_valid", if_m.tx_valid, 1'b0);
    chk("rst_mid.busy", if_m.busy, 1'b0);
    chk("rst_mid.fifo_full", if_m.fifo_full, 1'b0);
    chk("rst_mid.drop_count", if_m.drop_count, 8'h00);
    for (int i = 0; i < 3; i++) step();
    chk("rst_mid.still_idle", if_m.tx_valid, 1'b0);
    clear_logs();
    result       = 32'h40490FDB;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    drain("post_reset", 20);
    check_pi("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
